// File: rtl/jtdd_snd_romarb_pkg.sv
// Shared types and constants for the sound-board ROM arbiter.
package jtdd_snd_romarb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, GAP} state_t;

  localparam logic [1:0] ID_CPU = 2'd0;
  localparam logic [1:0] ID_AD0 = 2'd1;
  localparam logic [1:0] ID_AD1 = 2'd2;

  localparam logic [17:0] CPU_OFFSET_DEF = 18'h00000;
  localparam logic [17:0] AD0_OFFSET_DEF = 18'h10000;
  localparam logic [17:0] AD1_OFFSET_DEF = 18'h20000;

endpackage

// File: rtl/jtdd_romcache1.sv
// One-entry tag/data cache for a single ROM requester.
module jtdd_romcache1 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] addr,
  input  logic         cs,
  input  logic         fill,
  input  logic [W-1:0] fill_addr,
  input  logic [7:0]   fill_data,
  output logic [7:0]   data,
  output logic         ok,
  output logic         pend
);

  logic         valid_q, valid_d;
  logic [W-1:0] tag_q, tag_d;
  logic [7:0]   data_q, data_d;
  logic         hit_s;

  assign hit_s = valid_q && (tag_q == addr);
  assign ok    = cs && hit_s;
  assign pend  = cs && !hit_s;
  assign data  = data_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill) begin
      valid_d = 1'b1;
      tag_d   = fill_addr;
      data_d  = fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/jtdd_snd_romarb.sv
// Arbitrates the sound CPU and two ADPCM ROM requesters onto one SDRAM read port.
module jtdd_snd_romarb
  import jtdd_snd_romarb_pkg::*;
#(
  parameter int            AW         = 18,
  parameter logic [AW-1:0] CPU_OFFSET = AW'(CPU_OFFSET_DEF),
  parameter logic [AW-1:0] AD0_OFFSET = AW'(AD0_OFFSET_DEF),
  parameter logic [AW-1:0] AD1_OFFSET = AW'(AD1_OFFSET_DEF),
  parameter logic [7:0]    TOUT       = 8'd255
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [14:0]   cpu_addr,
  input  logic          cpu_cs,
  output logic [7:0]    cpu_data,
  output logic          cpu_ok,
  input  logic [15:0]   ad0_addr,
  input  logic          ad0_cs,
  output logic [7:0]    ad0_data,
  output logic          ad0_ok,
  input  logic [15:0]   ad1_addr,
  input  logic          ad1_cs,
  output logic [7:0]    ad1_data,
  output logic          ad1_ok,
  output logic [AW-1:0] mem_addr,
  output logic          mem_cs,
  input  logic [7:0]    mem_data,
  input  logic          mem_ok,
  output logic          tout
);

  state_t        state_q, state_d;
  logic [1:0]    gid_q, gid_d;
  logic [15:0]   gaddr_q, gaddr_d;
  logic          last_ad_q, last_ad_d;
  logic          last_cpu_q, last_cpu_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_cs_q, mem_cs_d;
  logic          tout_q, tout_d;
  logic          fill_s, pend_c, pend_a0, pend_a1, pend_ad;

  jtdd_romcache1 #(.W(15)) u_cpu (
    .clk(clk), .rstn(rstn), .addr(cpu_addr), .cs(cpu_cs),
    .fill(fill_s && gid_q == ID_CPU), .fill_addr(gaddr_q[14:0]), .fill_data(mem_data),
    .data(cpu_data), .ok(cpu_ok), .pend(pend_c)
  );

  jtdd_romcache1 #(.W(16)) u_ad0 (
    .clk(clk), .rstn(rstn), .addr(ad0_addr), .cs(ad0_cs),
    .fill(fill_s && gid_q == ID_AD0), .fill_addr(gaddr_q), .fill_data(mem_data),
    .data(ad0_data), .ok(ad0_ok), .pend(pend_a0)
  );

  jtdd_romcache1 #(.W(16)) u_ad1 (
    .clk(clk), .rstn(rstn), .addr(ad1_addr), .cs(ad1_cs),
    .fill(fill_s && gid_q == ID_AD1), .fill_addr(gaddr_q), .fill_data(mem_data),
    .data(ad1_data), .ok(ad1_ok), .pend(pend_a1)
  );

  assign pend_ad  = pend_a0 || pend_a1;
  assign mem_addr = mem_addr_q;
  assign mem_cs   = mem_cs_q;
  assign tout     = tout_q;

  always_comb begin
    state_d    = state_q;
    gid_d      = gid_q;
    gaddr_d    = gaddr_q;
    last_ad_d  = last_ad_q;
    last_cpu_d = last_cpu_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    tout_d     = 1'b0;
    fill_s     = 1'b0;
    case (state_q)
      IDLE: begin
        // CPU yields once after its own grant if an ADPCM channel is waiting
        if (pend_c && !(last_cpu_q && pend_ad)) begin
          gid_d      = ID_CPU;
          gaddr_d    = {1'b0, cpu_addr};
          mem_addr_d = CPU_OFFSET + AW'(cpu_addr);
          last_cpu_d = 1'b1;
          state_d    = REQ;
        end else if (pend_a0 && (!pend_a1 || last_ad_q)) begin
          gid_d      = ID_AD0;
          gaddr_d    = ad0_addr;
          mem_addr_d = AD0_OFFSET + AW'(ad0_addr);
          last_cpu_d = 1'b0;
          last_ad_d  = 1'b0;
          state_d    = REQ;
        end else if (pend_a1) begin
          gid_d      = ID_AD1;
          gaddr_d    = ad1_addr;
          mem_addr_d = AD1_OFFSET + AW'(ad1_addr);
          last_cpu_d = 1'b0;
          last_ad_d  = 1'b1;
          state_d    = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_ok) begin
          fill_s  = 1'b1;
          state_d = GAP;
        end else if (cnt_d == TOUT) begin
          tout_d  = 1'b1;
          state_d = GAP;
        end else begin
          state_d = WAIT;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_cs_d = (state_d == REQ) || (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      gid_q      <= ID_CPU;
      gaddr_q    <= 16'h0000;
      last_ad_q  <= 1'b1;
      last_cpu_q <= 1'b0;
      cnt_q      <= 8'd0;
      mem_addr_q <= '0;
      mem_cs_q   <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gid_q      <= gid_d;
      gaddr_q    <= gaddr_d;
      last_ad_q  <= last_ad_d;
      last_cpu_q <= last_cpu_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_cs_q   <= mem_cs_d;
      tout_q     <= tout_d;
    end
  end

endmodule
